// File: rtl/fp_subtractor_seq_if.sv
// Handshake bundle for the sequential single-precision subtractor.
// Master drives operands and out_ready; slave returns in_ready and results.
interface fp_subtractor_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision a - b, one bit of shift per clock.
// Define FP_SUB_RNE_EN for round-to-nearest-even; otherwise round-toward-zero.
module fp_subtractor_seq (
    input  logic               clk,
    input  logic               rst,
    fp_subtractor_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ARITH,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t      state;
    logic        sx;
    logic        sub;
    logic [8:0]  ex;
    logic [7:0]  diff;
    logic [27:0] mx;
    logic [27:0] my;
    logic [31:0] res_q;
    logic        ov_q;
    logic        ir_q;

    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic        a_big;
    logic        spec_hit;
    logic [31:0] spec_res;

    logic        rnd_inc;
    logic [24:0] rnd_m;
    logic [8:0]  rnd_e;
    logic [31:0] rnd_res;

    assign sa     = bus.a[31];
    assign sb     = ~bus.b[31];
    assign ea     = bus.a[30:23];
    assign eb     = bus.b[30:23];
    assign fa     = bus.a[22:0];
    assign fb     = bus.b[22:0];
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_big  = bus.a[30:0] >= bus.b[30:0];

    assign bus.in_ready  = ir_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = res_q;

    // Resolve NaN/inf/zero operands directly at acceptance
    always_comb begin
        spec_hit = 1'b1;
        spec_res = 32'd0;
        if (a_nan || b_nan) begin
            spec_res = 32'h7FC00000;
        end else if (a_inf && b_inf) begin
            spec_res = (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
        end else if (a_inf) begin
            spec_res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_res = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            spec_res = {sa & sb, 31'd0};
        end else if (a_zero) begin
            spec_res = {sb, bus.b[30:0]};
        end else if (b_zero) begin
            spec_res = {sa, bus.a[30:0]};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Round the normalized significand and pack the final word
    always_comb begin
`ifdef FP_SUB_RNE_EN
        rnd_inc = mx[2] & (mx[1] | mx[0] | mx[3]);
`else
        rnd_inc = 1'b0;
`endif
        rnd_m = {1'b0, mx[26:3]} + {24'd0, rnd_inc};
        rnd_e = ex;
        if (rnd_m[24]) begin
            rnd_m = rnd_m >> 1;
            rnd_e = ex + 9'd1;
        end
        if (rnd_e >= 9'd255) begin
            rnd_res = {sx, 8'hFF, 23'd0};
        end else begin
            rnd_res = {sx, rnd_e[7:0], rnd_m[22:0]};
        end
    end

    // Control FSM and datapath registers, one shift step per clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sx    <= 1'b0;
            sub   <= 1'b0;
            ex    <= 9'd0;
            diff  <= 8'd0;
            mx    <= 28'd0;
            my    <= 28'd0;
            res_q <= 32'd0;
            ov_q  <= 1'b0;
            ir_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ir_q <= 1'b0;
                        if (spec_hit) begin
                            res_q <= spec_res;
                            ov_q  <= 1'b1;
                            state <= DONE;
                        end else begin
                            sx    <= a_big ? sa : sb;
                            sub   <= sa ^ sb;
                            ex    <= {1'b0, a_big ? ea : eb};
                            diff  <= a_big ? (ea - eb) : (eb - ea);
                            mx    <= {2'b01, a_big ? fa : fb, 3'b000};
                            my    <= {2'b01, a_big ? fb : fa, 3'b000};
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (diff >= 8'd27) begin
                        my    <= {27'd0, |my};
                        state <= ARITH;
                    end else if (diff == 8'd0) begin
                        state <= ARITH;
                    end else begin
                        my   <= {1'b0, my[27:2], my[1] | my[0]};
                        diff <= diff - 8'd1;
                        if (diff == 8'd1) begin
                            state <= ARITH;
                        end
                    end
                end
                ARITH: begin
                    mx    <= sub ? (mx - my) : (mx + my);
                    state <= NORM;
                end
                NORM: begin
                    if (mx == 28'd0) begin
                        res_q <= 32'd0;
                        ov_q  <= 1'b1;
                        state <= DONE;
                    end else if (mx[27]) begin
                        mx    <= {1'b0, mx[27:2], mx[1] | mx[0]};
                        ex    <= ex + 9'd1;
                        state <= ROUND;
                    end else if (mx[26]) begin
                        state <= ROUND;
                    end else if (ex == 9'd1) begin
                        res_q <= {sx, 31'd0};
                        ov_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mx <= {mx[26:0], 1'b0};
                        ex <= ex - 9'd1;
                        if (mx[25]) begin
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    res_q <= rnd_res;
                    ov_q  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ov_q  <= 1'b0;
                        ir_q  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    ov_q  <= 1'b0;
                    ir_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: directed cases, handshake corners, random ops.
// Reference uses exact wide-integer arithmetic, then flush/round rules.
module tb_fp_subtractor_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    fp_subtractor_seq_if bus ();

    fp_subtractor_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact reference: lat = -1 where latency is not pinned down
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        logic sa, sb, rs, g, st, inc, big_a;
        logic [7:0] ea, eb;
        logic [279:0] va, vb, m;
        logic [24:0] mant;
        int p, sh, er, ex, ey, d, dc, s;
        sa = a[31];
        sb = ~b[31];
        ea = a[30:23];
        eb = b[30:23];
        lat = 1;
        r = 32'd0;
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0))
            r = 32'h7FC00000;
        else if (ea == 8'hFF && eb == 8'hFF)
            r = (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
        else if (ea == 8'hFF)
            r = {sa, 8'hFF, 23'd0};
        else if (eb == 8'hFF)
            r = {sb, 8'hFF, 23'd0};
        else if (ea == 0 && eb == 0)
            r = {sa & sb, 31'd0};
        else if (ea == 0)
            r = {sb, b[30:0]};
        else if (eb == 0)
            r = {sa, a[30:0]};
        else begin
            va = 280'({1'b1, a[22:0]}) << (ea - 1);
            vb = 280'({1'b1, b[22:0]}) << (eb - 1);
            big_a = va >= vb;
            rs = big_a ? sa : sb;
            if (sa == sb) m = va + vb;
            else m = big_a ? va - vb : vb - va;
            ex = big_a ? int'(ea) : int'(eb);
            ey = big_a ? int'(eb) : int'(ea);
            d = ex - ey;
            dc = (d == 0 || d >= 27) ? 1 : d;
            if (m == 0) begin
                r = 32'd0;
                lat = -1;
                return;
            end
            p = -1;
            for (int i = 279; i >= 0; i--)
                if (m[i] && p < 0) p = i;
            er = p - 22;
            if (er < 1) begin
                r = {rs, 31'd0};
                lat = -1;
                return;
            end
            s = (er >= ex) ? 1 : ex - er;
            lat = 3 + dc + s;
            sh = p - 23;
            mant = 25'(m >> sh);
            g = (sh > 0) ? m[sh-1] : 1'b0;
            st = (sh > 1) ? |(m & ((280'd1 << (sh - 1)) - 1)) : 1'b0;
`ifdef FP_SUB_RNE_EN
            inc = g & (st | mant[0]);
`else
            inc = 1'b0;
`endif
            mant = mant + {24'd0, inc};
            if (mant[24]) begin
                mant = mant >> 1;
                er++;
            end
            if (er >= 255) r = {rs, 8'hFF, 23'd0};
            else r = {rs, 8'(er), mant[22:0]};
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = bus.out_data;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r, er, a, b, held;
        int lat, el, n, seen, mode;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h40400000, 32'h3F800000, r, lat);
        check("3-1", r, 32'h40000000);
        check("3-1_lat", 32'(lat), 32'd5);
        check("ready_back", 32'(bus.in_ready), 32'd1);

        run_op(32'h3F800000, 32'h3F800000, r, lat);
        check("1-1", r, 32'h00000000);

        run_op(32'h3F800000, 32'hBF800000, r, lat);
        check("1+1", r, 32'h40000000);

        run_op(32'h3F800000, 32'h33000000, r, lat);
`ifdef FP_SUB_RNE_EN
        check("tie", r, 32'h3F800000);
`else
        check("tie", r, 32'h3F7FFFFF);
`endif
        check("tie_lat", 32'(lat), 32'd29);

        run_op(32'h7F800000, 32'h7F800000, r, lat);
        check("inf-inf", r, 32'h7FC00000);
        check("inf-inf_lat", 32'(lat), 32'd1);

        run_op(32'h7F800000, 32'h3F800000, r, lat);
        check("inf-1", r, 32'h7F800000);

        run_op(32'h80000000, 32'h00000000, r, lat);
        check("-0-0", r, 32'h80000000);

        // Backpressure with an ignored in_valid pulse while busy
        @(negedge clk);
        bus.a = 32'h40400000;
        bus.b = 32'h3F800000;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        held = bus.out_data;
        check("bp_data", held, 32'h40000000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = (k == 1);
            bus.a = 32'h3F800000;
            bus.b = 32'hBF800000;
            check($sformatf("bp_hold%0d", k), bus.out_data, held);
            check($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_busy%0d", k), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_valid", 32'(bus.out_valid), 32'd0);
        check("bp_xfer_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("bp_no_ghost", 32'(seen), 32'd0);

        // Reset in the middle of a long alignment
        @(negedge clk);
        bus.a = 32'h3F800000;
        bus.b = 32'h33000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_no_out", 32'(seen), 32'd0);

        run_op(32'h40400000, 32'h3F800000, r, lat);
        check("post_rst", r, 32'h40000000);

        // Random operands against the exact reference
        for (int i = 0; i < 250; i++) begin
            a = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0: b = $urandom;
                1: b = {1'($urandom), 8'(int'(a[30:23]) + $urandom_range(0, 6) - 3),
                        23'($urandom)};
                2: b = {1'($urandom), 8'(int'(a[30:23]) - $urandom_range(20, 30)),
                        23'($urandom)};
                3: b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 255))};
                default: begin
                    a = {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
                    b = {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
                end
            endcase
            model(a, b, er, el);
            run_op(a, b, r, lat);
            check($sformatf("rand%0d a=%h b=%h", i, a, b), r, er);
            check($sformatf("rand%0d_timeout", i), 32'(lat < 100), 32'd1);
            if (el > 0)
                check($sformatf("rand%0d_lat a=%h b=%h", i, a, b),
                      32'(lat), 32'(el));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
